// File: rtl/platform_rider.sv
// Player vertical/horizontal motion for a platform game: falls under gravity,
// rides a moving ground, rests on the floor, and jumps on request.
module platform_rider #(
    parameter int INITIAL_X     = 280,
    parameter int INITIAL_Y     = 100,
    parameter int GRAVITY       = 5,
    parameter int MAX_Y_SPEED   = 400,
    parameter int JUMP_SPEED    = -250,
    parameter int RIDE_OFFSET_Y = 32,
    parameter int FLOOR_Y       = 420
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               startOfFrame,
    input  logic signed [10:0] groundTopLeftX,
    input  logic signed [10:0] groundTopLeftY,
    input  logic               groundHit,
    input  logic               jumpKey,
    output logic signed [10:0] topLeftX,
    output logic signed [10:0] topLeftY,
    output logic               riding
);

    typedef enum logic [1:0] {FALL, RIDE, FLOOR} state_t;

    localparam logic signed [31:0] INIT_X_FP  = 32'(INITIAL_X * 64);
    localparam logic signed [31:0] INIT_Y_FP  = 32'(INITIAL_Y * 64);
    localparam logic signed [31:0] FLOOR_FP   = 32'(FLOOR_Y * 64);
    localparam logic signed [31:0] MAX_X_FP   = 32'(639 * 64);
    localparam logic signed [31:0] GRAV       = 32'(GRAVITY);
    localparam logic signed [31:0] MAX_SPD    = 32'(MAX_Y_SPEED);
    localparam logic signed [31:0] JUMP_SPD   = 32'(JUMP_SPEED);
    localparam logic signed [31:0] RIDE_OFF   = 32'(RIDE_OFFSET_Y);

    state_t             state_q, state_d;
    logic signed [31:0] x_q, x_d;
    logic signed [31:0] y_q, y_d;
    logic signed [31:0] yspeed_q, yspeed_d;
    logic               hit_q, hit_d;
    logic               valid_q, valid_d;
    logic signed [10:0] prev_gx_q, prev_gx_d;
    logic signed [10:0] prev_gy_q, prev_gy_d;
    logic               riding_q, riding_d;

    logic signed [31:0] gx_ext, gy_ext, prev_gx_ext;
    logic signed [31:0] delta_x, ride_y, fall_y, fall_speed;
    logic               hit_eff;

    always_comb begin
        gx_ext      = {{21{groundTopLeftX[10]}}, groundTopLeftX};
        gy_ext      = {{21{groundTopLeftY[10]}}, groundTopLeftY};
        prev_gx_ext = {{21{prev_gx_q[10]}}, prev_gx_q};
        delta_x     = valid_q ? (gx_ext - prev_gx_ext) : '0;
        ride_y      = (gy_ext - RIDE_OFF) <<< 6;
        fall_y      = y_q + yspeed_q;
        fall_speed  = (yspeed_q + GRAV > MAX_SPD) ? MAX_SPD : (yspeed_q + GRAV);
        // a hit arriving in the frame-start cycle itself still counts
        hit_eff     = hit_q | groundHit;

        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        yspeed_d  = yspeed_q;
        hit_d     = hit_q | groundHit;
        valid_d   = valid_q;
        prev_gx_d = prev_gx_q;
        prev_gy_d = prev_gy_q;

        if (startOfFrame) begin
            hit_d     = 1'b0;
            valid_d   = 1'b1;
            prev_gx_d = groundTopLeftX;
            prev_gy_d = groundTopLeftY;

            unique case (state_q)
                FALL: begin
                    if (hit_eff && (yspeed_q >= 0)) begin
                        state_d  = RIDE;
                        y_d      = ride_y;
                        yspeed_d = '0;
                    end else if (fall_y >= FLOOR_FP) begin
                        state_d  = FLOOR;
                        y_d      = FLOOR_FP;
                        yspeed_d = '0;
                    end else begin
                        y_d      = fall_y;
                        yspeed_d = fall_speed;
                    end
                end
                RIDE: begin
                    if (jumpKey) begin
                        state_d  = FALL;
                        yspeed_d = JUMP_SPD;
                        y_d      = y_q + JUMP_SPD;
                    end else if (!hit_eff) begin
                        state_d  = FALL;
                        yspeed_d = '0;
                    end else begin
                        x_d      = x_q + (delta_x <<< 6);
                        y_d      = ride_y;
                        yspeed_d = '0;
                    end
                end
                FLOOR: begin
                    if (jumpKey) begin
                        state_d  = FALL;
                        yspeed_d = JUMP_SPD;
                        y_d      = y_q + JUMP_SPD;
                    end else if (hit_eff) begin
                        state_d  = RIDE;
                        y_d      = ride_y;
                        yspeed_d = '0;
                    end
                end
                default: state_d = FALL;
            endcase

            if (x_d < 0)             x_d = '0;
            else if (x_d > MAX_X_FP) x_d = MAX_X_FP;
            if (y_d < 0) begin
                y_d      = '0;
                yspeed_d = '0;
            end
        end

        riding_d = (state_d == RIDE);
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q   <= FALL;
            x_q       <= INIT_X_FP;
            y_q       <= INIT_Y_FP;
            yspeed_q  <= '0;
            hit_q     <= 1'b0;
            valid_q   <= 1'b0;
            prev_gx_q <= '0;
            prev_gy_q <= '0;
            riding_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            yspeed_q  <= yspeed_d;
            hit_q     <= hit_d;
            valid_q   <= valid_d;
            prev_gx_q <= prev_gx_d;
            prev_gy_q <= prev_gy_d;
            riding_q  <= riding_d;
        end
    end

    assign topLeftX = x_q[16:6];
    assign topLeftY = y_q[16:6];
    assign riding   = riding_q;

endmodule

// File: doc/platform_rider.md
PLATFORM_RIDER -- requirements
Module: platform_rider

Interface
REQ-001 SHALL have parameter INITIAL_X, default 280, player start X (pixels).
REQ-002 SHALL have parameter INITIAL_Y, default 100, player start Y (pixels).
REQ-003 SHALL have parameter GRAVITY, default 5, Y-speed increment per frame (1/64 px units).
REQ-004 SHALL have parameter MAX_Y_SPEED, default 400, downward speed cap (1/64 px units).
REQ-005 SHALL have parameter JUMP_SPEED, default -250, Y speed loaded on jump (1/64 px units).
REQ-006 SHALL have parameter RIDE_OFFSET_Y, default 32, pixels between player top and ground top while riding.
REQ-007 SHALL have parameter FLOOR_Y, default 420, lowest allowed player top Y (pixels).
REQ-008 SHALL have port clk, input, 1, the single system clock.
REQ-009 SHALL have port resetN, input, 1, asynchronous active-low reset.
REQ-010 SHALL have port startOfFrame, input, 1, one-cycle pulse per frame (30 Hz).
REQ-011 SHALL have ports groundTopLeftX and groundTopLeftY, input, 11 signed each, moving-ground position from the ground mover.
REQ-012 SHALL have port groundHit, input, 1, pixel-level player/ground overlap, any cycle.
REQ-013 SHALL have port jumpKey, input, 1, level jump request.
REQ-014 SHALL have ports topLeftX and topLeftY, output, 11 signed each, player position in pixels.
REQ-015 SHALL have port riding, output, 1, high while in state RIDE.

Function
REQ-016 SHALL hold position as 32-bit signed fixed point ×64; outputs SHALL be that value arithmetic-shifted right by 6 (floor).
REQ-017 SHALL implement states FALL, RIDE, FLOOR; all updates SHALL occur only in the cycle startOfFrame=1, except hit latching.
REQ-018 SHALL latch groundHit into hitFlag on any cycle; hitFlag SHALL clear at each startOfFrame after being evaluated; a hit in the startOfFrame cycle itself SHALL count for that frame.
REQ-019 SHALL sample groundTopLeftX/Y into prevGroundX/Y at every startOfFrame; deltaX = current − prev; deltaX SHALL be 0 on the first frame after reset (sampleValid flag).
REQ-020 FALL: Yspeed ← min(Yspeed+GRAVITY, MAX_Y_SPEED); Y_fp ← Y_fp + old Yspeed; X unchanged.
REQ-021 FALL→RIDE when hitFlag=1 and Yspeed ≥ 0: Y ← (groundTopLeftY − RIDE_OFFSET_Y)×64, Yspeed ← 0, same frame.
REQ-022 FALL→FLOOR when new Y_fp ≥ FLOOR_Y×64 (and no REQ-021 landing): Y clamped to FLOOR_Y×64, Yspeed ← 0.
REQ-023 Hit while Yspeed < 0 (rising) SHALL be ignored.
REQ-024 RIDE: X_fp ← X_fp + deltaX×64; Y ← (groundTopLeftY − RIDE_OFFSET_Y)×64; Yspeed = 0.
REQ-025 RIDE→FALL when hitFlag=0 at startOfFrame (walked off); Yspeed starts at 0.
REQ-026 From RIDE or FLOOR, jumpKey=1 at startOfFrame → FALL, Yspeed ← JUMP_SPEED, Y_fp ← Y_fp + JUMP_SPEED that frame; jump SHALL take priority over hit and ride-follow.
REQ-027 FLOOR: position held; FLOOR→RIDE on hitFlag=1.
REQ-028 X_fp SHALL clamp to [0, 639×64]; Y_fp SHALL never go below 0 (clamp, Yspeed ← 0).

Reset
REQ-029 On resetN=0, asynchronously: state=FALL, X=INITIAL_X×64, Y=INITIAL_Y×64, Yspeed=0, hitFlag=0, sampleValid=0, prevGround=0; outputs topLeftX=280, topLeftY=100, riding=0.
REQ-030 Reset asserted mid-frame or mid-jump SHALL abort all motion and restore REQ-029 values; first frame after release SHALL be FALL with deltaX=0.

Verification
REQ-031 Reset release, 2 frames, no hit -> Yspeed 5 then 10; Y_fp 6400 then 6405 then 6415; topLeftY stays 100.
REQ-032 Falling, groundHit pulse mid-frame, groundTopLeftY=226 -> next startOfFrame state RIDE, topLeftY=194, riding=1.
REQ-033 RIDE, groundTopLeftX steps 360→362 per frame, hit held -> topLeftX +2 per frame, topLeftY tracks groundTopLeftY−32.
REQ-034 RIDE, jumpKey and groundHit together at startOfFrame -> FALL, Yspeed=-250, topLeftY decreases by 4 (floor of 250/64 applied to fixed point), riding=0.
REQ-035 Fall with no hit from Y=100 -> state FLOOR, topLeftY=420 exactly, Yspeed=0; later jumpKey -> FALL with Yspeed=-250.
REQ-036 resetN pulsed low during RIDE -> immediately topLeftX=280, topLeftY=100, riding=0; next frame deltaX=0 regardless of ground position.
